// File: rtl/hex_display_arbiter_if.sv
// Requester-side bus of the hex display arbiter.
// Requesters drive req/data; the arbiter answers with grant/ack.
interface hex_display_arbiter_if #(
  parameter int c_requesters = 4,
  parameter int c_data_len   = 64
);
  logic [c_requesters-1:0]            req;
  logic [c_requesters*c_data_len-1:0] data;
  logic [c_requesters-1:0]            grant;
  logic [c_requesters-1:0]            ack;

  modport master (output req, output data, input grant, input ack);
  modport slave  (input req, input data, output grant, output ack);
endinterface

// File: rtl/hex_display_arbiter.sv
// Round-robin arbiter sharing the dynamic half of the hex display word.
// The owner's value is latched only on a video frame boundary (scan at 0,0),
// and each owner keeps the display for c_dwell cycles unless nobody else
// is waiting. The static upper half is passed through with one register.
module hex_display_arbiter #(
  parameter int c_requesters = 4,
  parameter int c_data_len   = 64,
  parameter int c_static_len = 64,
  parameter int c_dwell      = 25000000
) (
  input  logic                                 clk,
  input  logic                                 resetn,
  hex_display_arbiter_if.slave                 bus,
  input  logic [c_static_len-1:0]              static_data,
  input  logic [6:0]                           x,
  input  logic [5:0]                           y,
  output logic [c_data_len+c_static_len-1:0]   display
);

  localparam int c_ptr_w = $clog2(c_requesters);
  localparam int c_cnt_w = $clog2(c_dwell);
  localparam logic [c_cnt_w-1:0] c_reload = c_cnt_w'(c_dwell - 1);
  localparam logic [c_ptr_w-1:0] c_last   = c_ptr_w'(c_requesters - 1);
  localparam logic [c_requesters-1:0] c_one = {{(c_requesters-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {IDLE, WAIT_FRAME, SHOW} state_t;

  state_t                  state_reg, state_next;
  logic [c_ptr_w-1:0]      rr_ptr_reg, rr_ptr_next;
  logic [c_ptr_w-1:0]      owner_reg, owner_next;
  logic [c_cnt_w-1:0]      cnt_reg, cnt_next;
  logic [c_requesters-1:0] grant_reg, grant_next;
  logic [c_requesters-1:0] ack_reg, ack_next;
  logic [c_data_len-1:0]   dyn_reg, dyn_next;
  logic [c_static_len-1:0] static_reg;
  logic                    at_origin_reg;

  logic [1:0]              rst_sync_reg;
  logic                    rst_n;
  logic                    at_origin;
  logic                    fb;
  logic [c_ptr_w-1:0]      sel;
  logic [c_ptr_w-1:0]      owner_inc;
  logic                    req_owner;
  logic                    others_pending;
  logic [c_data_len-1:0]   data_arr [c_requesters];

  // Reset asserts immediately but is released only on a clock edge.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) rst_sync_reg <= 2'b00;
    else         rst_sync_reg <= {rst_sync_reg[0], 1'b1};
  end
  assign rst_n = rst_sync_reg[1];

  genvar gi;
  generate
    for (gi = 0; gi < c_requesters; gi++) begin : g_unpack
      assign data_arr[gi] = bus.data[gi*c_data_len +: c_data_len];
    end
  endgenerate

  // One strobe per arrival at the origin, however long the scan sits there.
  assign at_origin      = (x == 7'd0) && (y == 6'd0);
  assign fb             = at_origin & ~at_origin_reg;
  assign owner_inc      = (owner_reg == c_last) ? '0 : owner_reg + 1'b1;
  assign req_owner      = bus.req[owner_reg];
  assign others_pending = |(bus.req & ~grant_reg);

  // First pending requester at or above rr_ptr, wrapping modulo N.
  always_comb begin
    logic found;
    found = 1'b0;
    sel   = rr_ptr_reg;
    for (int k = 0; k < c_requesters; k++) begin
      int idx;
      idx = int'(rr_ptr_reg) + k;
      if (idx >= c_requesters) idx = idx - c_requesters;
      if (!found && bus.req[idx]) begin
        found = 1'b1;
        sel   = c_ptr_w'(idx);
      end
    end
  end

  // Next-state and output logic of the ownership FSM.
  always_comb begin
    state_next  = state_reg;
    rr_ptr_next = rr_ptr_reg;
    owner_next  = owner_reg;
    cnt_next    = cnt_reg;
    grant_next  = grant_reg;
    ack_next    = '0;
    dyn_next    = dyn_reg;
    case (state_reg)
      IDLE: begin
        if (|bus.req) begin
          owner_next = sel;
          grant_next = c_one << sel;
          state_next = WAIT_FRAME;
        end
      end
      WAIT_FRAME: begin
        if (!req_owner) begin
          grant_next  = '0;
          rr_ptr_next = owner_inc;
          state_next  = IDLE;
        end else if (fb) begin
          dyn_next   = data_arr[owner_reg];
          ack_next   = grant_reg;
          cnt_next   = c_reload;
          state_next = SHOW;
        end
      end
      SHOW: begin
        if (!req_owner) begin
          // A dropping owner never gets a final latch.
          grant_next  = '0;
          rr_ptr_next = owner_inc;
          state_next  = IDLE;
        end else begin
          if (fb) dyn_next = data_arr[owner_reg];
          if (cnt_reg == '0) begin
            if (others_pending) begin
              grant_next  = '0;
              rr_ptr_next = owner_inc;
              state_next  = IDLE;
            end else begin
              cnt_next = c_reload;
            end
          end else begin
            cnt_next = cnt_reg - 1'b1;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= IDLE;
      rr_ptr_reg    <= '0;
      owner_reg     <= '0;
      cnt_reg       <= '0;
      grant_reg     <= '0;
      ack_reg       <= '0;
      dyn_reg       <= '0;
      static_reg    <= '0;
      at_origin_reg <= 1'b0;
    end else begin
      state_reg     <= state_next;
      rr_ptr_reg    <= rr_ptr_next;
      owner_reg     <= owner_next;
      cnt_reg       <= cnt_next;
      grant_reg     <= grant_next;
      ack_reg       <= ack_next;
      dyn_reg       <= dyn_next;
      static_reg    <= static_data;
      at_origin_reg <= at_origin;
    end
  end

  assign bus.grant = grant_reg;
  assign bus.ack   = ack_reg;
  assign display   = {static_reg, dyn_reg};

endmodule
